// File: rtl/noc_output_arbiter_pkg.sv
// Purpose: shared types and defaults for the router output-port arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package noc_output_arbiter_pkg;

    // Arbiter lock state: either no owner, or one input holds the switch until its tail.
    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } noc_arb_state_e;

    localparam int Noc_Output_Ports = 5;
    localparam int Noc_Arb_Timeout  = 256;

    // Index/counter width that never collapses to zero bits for degenerate sizes.
    function automatic int noc_min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// Purpose: round-robin pick of the first requester at or after ptr (wrapping).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of req and ptr.
//
// Ports:
//   req    : request vector, one bit per input port
//   ptr    : highest-priority index for this pick (must be < N)
//   winner : index of the chosen requester (0 when none)
//   found  : at least one request bit was set
module noc_rr_picker
    import noc_output_arbiter_pkg::*;
#(
    parameter  int N  = Noc_Output_Ports,
    localparam int IW = noc_min1_clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;

    // Duplicating the vector and shifting right by ptr puts port ptr at bit 0 and
    // lets the wrapped ports follow naturally, so a plain LSB-first priority
    // encode yields the round-robin winner as an offset from ptr.
    always_comb begin
        int sum;
        sum     = 0;
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        found   = 1'b0;
        winner  = '0;
        // Descending scan so the lowest set offset is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                winner = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Purpose: wormhole round-robin arbiter owning one router output switch.
// Latency: request->grant 1 cycle; tail->next grant 1 cycle with no idle bubble.
// Backpressure: lock holds while the switch stalls; a stuck lock raises a sticky timeout.
//
// Ports:
//   noc_clk, noc_rst_n : router clock, synchronous active-low reset
//   i_req              : per-input header-at-head request for this output
//   i_xfer             : a flit crossed the switch this cycle
//   i_xfer_tail        : that flit carried the tail bit (only meaningful with i_xfer)
//   o_grant            : registered one-hot switch select (zero when idle)
//   o_busy             : output is locked to a packet
//   o_owner            : index of the granted input, 0 when idle
//   o_timeout          : sticky, lock stalled LOCK_TIMEOUT cycles without a transfer
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter  int N_PORTS      = Noc_Output_Ports,
    parameter  int LOCK_TIMEOUT = Noc_Arb_Timeout,
    localparam int OWN_W        = noc_min1_clog2(N_PORTS),
    localparam int CNT_W        = noc_min1_clog2(LOCK_TIMEOUT + 1)
) (
    input  logic               noc_clk,
    input  logic               noc_rst_n,
    input  logic [N_PORTS-1:0] i_req,
    input  logic               i_xfer,
    input  logic               i_xfer_tail,
    output logic [N_PORTS-1:0] o_grant,
    output logic               o_busy,
    output logic [OWN_W-1:0]   o_owner,
    output logic               o_timeout
);

    localparam bit                 TIMEOUT_ON  = (LOCK_TIMEOUT != 0);
    localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(LOCK_TIMEOUT);
    localparam logic [N_PORTS-1:0] GRANT_LSB   = N_PORTS'(1);
    localparam logic [OWN_W-1:0]   LAST_PORT   = OWN_W'(N_PORTS - 1);

    noc_arb_state_e     state_q,     state_d;
    logic [N_PORTS-1:0] grant_q,     grant_d;
    logic [OWN_W-1:0]   owner_q,     owner_d;
    logic [OWN_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               timeout_q,   timeout_d;

    logic [OWN_W-1:0]   pick_idx;
    logic               pick_found;
    logic               take;

    // rr_ptr_q is already rotated past the last winner, so the same picker
    // serves both a fresh arbitration from idle and the back-to-back handover
    // on a tail.
    noc_rr_picker #(
        .N      (N_PORTS)
    ) u_picker (
        .req    (i_req),
        .ptr    (rr_ptr_q),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;
        take        = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Transfers seen while idle are stray and deliberately ignored.
                take = pick_found;
            end
            ARB_LOCKED: begin
                // Requests never disturb a held lock; only the owner's tail ends it.
                if (i_xfer) begin
                    stall_cnt_d = '0;
                    if (i_xfer_tail) begin
                        take = pick_found;
                        if (!pick_found) begin
                            state_d = ARB_IDLE;
                            grant_d = '0;
                            owner_d = '0;
                        end
                    end
                end else if (TIMEOUT_ON && (stall_cnt_q != TIMEOUT_CNT)) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                // Flag only; the lock is kept because breaking a wormhole
                // mid-packet would corrupt it downstream.
                if (TIMEOUT_ON && (stall_cnt_d == TIMEOUT_CNT)) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                owner_d = '0;
            end
        endcase

        if (take) begin
            state_d     = ARB_LOCKED;
            grant_d     = GRANT_LSB << pick_idx;
            owner_d     = pick_idx;
            rr_ptr_d    = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_busy    = (state_q == ARB_LOCKED);
    assign o_owner   = owner_q;
    assign o_timeout = timeout_q;

endmodule
